// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the pad configuration controller.
// The configuration word packs output mode, drive/slew/input-enable and the pull controls.
package pad_cfg_pkg;

  localparam int CFG_W     = 7;
  localparam int MODE_LSB  = 0;
  localparam int CS_BIT    = 2;
  localparam int SL_BIT    = 3;
  localparam int IE_BIT    = 4;
  localparam int PU_BIT    = 5;
  localparam int PD_BIT    = 6;

  typedef enum logic [1:0] {
    MODE_CORE = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_HIGH = 2'd2,
    MODE_HIZ  = 2'd3
  } pad_mode_e;

  typedef struct packed {
    logic      pd;
    logic      pu;
    logic      ie;
    logic      sl;
    logic      cs;
    pad_mode_e mode;
  } pad_cfg_t;

  localparam pad_cfg_t PAD_CFG_RESET = '{pd: 1'b0, pu: 1'b0, ie: 1'b1, sl: 1'b0, cs: 1'b0,
                                         mode: MODE_CORE};

  typedef enum logic {
    ST_IDLE,
    ST_COMMIT
  } ctrl_state_e;

  // Input-only pads have no output path; only the pull controls survive a write.
  function automatic pad_cfg_t input_pad_word(input logic [CFG_W-1:0] wdata);
    logic [CFG_W-1:0] w;
    w = '0;
    w[PD_BIT] = wdata[PD_BIT];
    w[PU_BIT] = wdata[PU_BIT];
    return pad_cfg_t'(w);
  endfunction

endpackage

// File: rtl/pad_cfg_bidir_mux.sv
// Combinational resolution of one bidir pad: output mode override and pull-down-wins rule.
import pad_cfg_pkg::*;

module pad_cfg_bidir_mux (
  input  pad_cfg_t cfg,
  input  logic     core_out,
  input  logic     core_oe,
  output logic     pad_out,
  output logic     pad_oe,
  output logic     pad_cs,
  output logic     pad_sl,
  output logic     pad_ie,
  output logic     pad_pu,
  output logic     pad_pd
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch can be inferred.
    pad_out = 1'b0;
    pad_oe  = 1'b0;
    unique case (cfg.mode)
      MODE_CORE: begin
        pad_out = core_out;
        pad_oe  = core_oe;
      end
      MODE_LOW: begin
        pad_out = 1'b0;
        pad_oe  = 1'b1;
      end
      MODE_HIGH: begin
        pad_out = 1'b1;
        pad_oe  = 1'b1;
      end
      MODE_HIZ: begin
        pad_out = 1'b0;
        pad_oe  = 1'b0;
      end
      default: ;
    endcase
  end

  assign pad_cs = cfg.cs;
  assign pad_sl = cfg.sl;
  assign pad_ie = cfg.ie;
  assign pad_pu = cfg.pu & ~cfg.pd;
  assign pad_pd = cfg.pd;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Shadow/active pad configuration store with a staggered group-wise commit.
// Bidir pads are addressed first, then input pads.
import pad_cfg_pkg::*;

module pad_cfg_ctrl #(
  parameter  int NUM_INPUT_PADS = 16,
  parameter  int NUM_BIDIR_PADS = 37,
  parameter  int GROUP          = 4,
  localparam int ADDR_W         = $clog2(NUM_BIDIR_PADS + NUM_INPUT_PADS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [CFG_W-1:0]          cfg_wdata,
  output logic [CFG_W-1:0]          cfg_rdata,
  output logic                      cfg_rvalid,
  input  logic                      cfg_commit,
  output logic                      cfg_done,
  output logic [1:0]                cfg_err,
  input  logic                      cfg_err_clr,
  input  logic [NUM_BIDIR_PADS-1:0] core_out,
  input  logic [NUM_BIDIR_PADS-1:0] core_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd
);

  localparam int NUM_PADS = NUM_BIDIR_PADS + NUM_INPUT_PADS;
  localparam int BASE_W   = $clog2(NUM_PADS + GROUP) + 1;

  ctrl_state_e       state_q;
  logic [BASE_W-1:0] base_q;
  pad_cfg_t          shadow_q [NUM_PADS];
  pad_cfg_t          active_q [NUM_PADS];

  logic     access;
  logic     addr_ok;
  logic     last_group;
  pad_cfg_t wr_word;
  logic [1:0] new_err;

  assign cfg_ready  = (state_q == ST_IDLE);
  assign access     = cfg_ready & cfg_valid;
  assign addr_ok    = (int'(cfg_addr) < NUM_PADS);
  assign last_group = (int'(base_q) + GROUP >= NUM_PADS);
  assign wr_word    = (int'(cfg_addr) < NUM_BIDIR_PADS) ? pad_cfg_t'(cfg_wdata)
                                                        : input_pad_word(cfg_wdata);
  assign new_err[0] = access & ~addr_ok;
  assign new_err[1] = access & cfg_we & addr_ok & cfg_wdata[PU_BIT] & cfg_wdata[PD_BIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= '0;
      // NOTE: both register files are reset because every pad must leave reset in a known safe state.
      for (int i = 0; i < NUM_PADS; i++) begin
        shadow_q[i] <= PAD_CFG_RESET;
        active_q[i] <= PAD_CFG_RESET;
      end
    end else begin
      cfg_rvalid <= 1'b0;
      cfg_done   <= 1'b0;
      // A fresh error in the clearing cycle still lands.
      cfg_err    <= (cfg_err_clr ? 2'b00 : cfg_err) | new_err;

      unique case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (cfg_we) begin
              if (addr_ok) shadow_q[cfg_addr] <= wr_word;
            end else begin
              cfg_rvalid <= 1'b1;
              cfg_rdata  <= addr_ok ? shadow_q[cfg_addr] : '0;
            end
          end
          if (cfg_commit) begin
            state_q <= ST_COMMIT;
            base_q  <= '0;
          end
        end
        ST_COMMIT: begin
          // Copy one window of GROUP pads per cycle; the final window may be short.
          for (int i = 0; i < NUM_PADS; i++) begin
            if (i >= int'(base_q) && i < int'(base_q) + GROUP) active_q[i] <= shadow_q[i];
          end
          if (last_group) begin
            state_q  <= ST_IDLE;
            cfg_done <= 1'b1;
          end else begin
            base_q <= base_q + BASE_W'(GROUP);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BIDIR_PADS; b++) begin : g_bidir
    pad_cfg_bidir_mux u_mux (
      .cfg      (active_q[b]),
      .core_out (core_out[b]),
      .core_oe  (core_oe[b]),
      .pad_out  (bidir_out[b]),
      .pad_oe   (bidir_oe[b]),
      .pad_cs   (bidir_cs[b]),
      .pad_sl   (bidir_sl[b]),
      .pad_ie   (bidir_ie[b]),
      .pad_pu   (bidir_pu[b]),
      .pad_pd   (bidir_pd[b])
    );
  end

  for (genvar n = 0; n < NUM_INPUT_PADS; n++) begin : g_input
    assign input_pu[n] = active_q[NUM_BIDIR_PADS + n].pu & ~active_q[NUM_BIDIR_PADS + n].pd;
    assign input_pd[n] = active_q[NUM_BIDIR_PADS + n].pd;
  end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl: access port, staggered commit, error flags and reset abort.
module tb_pad_cfg_ctrl;

  localparam int NI = 16;
  localparam int NB = 37;
  localparam int AW = $clog2(NB + NI);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [6:0]    cfg_wdata;
  logic [6:0]    cfg_rdata;
  logic          cfg_rvalid;
  logic          cfg_commit;
  logic          cfg_done;
  logic [1:0]    cfg_err;
  logic          cfg_err_clr;
  logic [NB-1:0] core_out, core_oe;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_pu, input_pd;

  int checks   = 0;
  int failures = 0;

  pad_cfg_ctrl #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .cfg_commit(cfg_commit), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr),
    .core_out(core_out), .core_oe(core_oe),
    .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .input_pu(input_pu), .input_pd(input_pd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not terminate");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int addr, input logic [6:0] data);
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = data;
    tick();
    cfg_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic read(input int addr);
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = AW'(addr);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!cfg_ready && guard < 40) begin
      tick();
      guard++;
    end
    check(tag, 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    int low_cycles;
    int done_early;
    int pd52_early;
    int guard;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_commit = 1'b0; cfg_err_clr = 1'b0;
    core_out = '1; core_oe = '1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state and core pass-through on pad 0
    check("rst_ready",  32'(cfg_ready),  32'd1);
    check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
    check("rst_done",   32'(cfg_done),   32'd0);
    check("rst_err",    32'(cfg_err),    32'd0);
    check("rst_rdata",  32'(cfg_rdata),  32'd0);
    check("rst_out0",   32'(bidir_out[0]), 32'd1);
    check("rst_oe0",    32'(bidir_oe[0]),  32'd1);
    check("rst_ie0",    32'(bidir_ie[0]),  32'd1);
    check("rst_pupd0",  32'({bidir_pu[0], bidir_pd[0]}), 32'd0);
    check("rst_inpd",   32'(input_pd), 32'd0);

    // Zero-latency core path
    core_out[0] = 1'b0;
    #1;
    check("core_comb_out0", 32'(bidir_out[0]), 32'd0);
    core_out[0] = 1'b1;

    // Write HIGH to pad 3: active untouched until commit
    core_out[3] = 1'b0; core_oe[3] = 1'b0;
    write(3, 7'h02);
    check("wr3_out_unchanged", 32'({bidir_out[3], bidir_oe[3]}), 32'd0);
    check("wr3_err", 32'(cfg_err), 32'd0);
    read(3);
    check("rd3_rvalid", 32'(cfg_rvalid), 32'd1);
    check("rd3_rdata",  32'(cfg_rdata),  32'h02);
    tick();
    check("rd3_rvalid_pulse", 32'(cfg_rvalid), 32'd0);

    // Input pad 3 with pu&pd: only pulls stored, conflict flagged
    write(40, 7'h7F);
    check("wr40_err", 32'(cfg_err), 32'b10);
    read(40);
    check("rd40_rdata", 32'(cfg_rdata), 32'h60);
    write(52, 7'h40);
    check("inpd3_precommit", 32'(input_pd[3]), 32'd0);

    // Full commit: 14 cycles of ready low, group 0 first, pad 52 last
    low_cycles = 0; done_early = 0; pd52_early = 0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    if (!cfg_ready) low_cycles++;
    check("cm_oe3_before_copy", 32'(bidir_oe[3]), 32'd0);
    tick();
    if (!cfg_ready) low_cycles++;
    check("cm_pad3_after_g0", 32'({bidir_out[3], bidir_oe[3]}), 32'b11);
    check("cm_inpd3_not_yet", 32'(input_pd[3]), 32'd0);
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = AW'(5); cfg_wdata = 7'h03;
    cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    if (!cfg_ready) low_cycles++;
    guard = 0;
    while (!cfg_ready && guard < 40) begin
      if (cfg_done) done_early++;
      if (input_pd[15]) pd52_early++;
      tick();
      guard++;
      if (!cfg_ready) low_cycles++;
    end
    check("cm_low_cycles", 32'(low_cycles), 32'd14);
    check("cm_done_at_ready", 32'(cfg_done), 32'd1);
    check("cm_done_early", 32'(done_early), 32'd0);
    check("cm_pd52_early", 32'(pd52_early), 32'd0);
    check("cm_pd52_final", 32'(input_pd[15]), 32'd1);
    check("cm_in3_pulls", 32'({input_pu[3], input_pd[3]}), 32'b01);
    check("cm_err_sticky", 32'(cfg_err), 32'b10);
    tick();
    check("cm_done_pulse", 32'(cfg_done), 32'd0);
    check("cm_no_recommit", 32'(cfg_ready), 32'd1);
    read(5);
    check("cm_ignored_write", 32'(cfg_rdata), 32'h10);

    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    check("err_clr", 32'(cfg_err), 32'd0);

    // Out-of-range address
    write(53, 7'h03);
    check("bad_wr_err", 32'(cfg_err), 32'b01);
    read(53);
    check("bad_rd_rvalid", 32'(cfg_rvalid), 32'd1);
    check("bad_rd_rdata",  32'(cfg_rdata),  32'd0);
    read(52);
    check("bad_wr_no_change", 32'(cfg_rdata), 32'h40);
    cfg_err_clr = 1'b1;
    write(60, 7'h00);
    cfg_err_clr = 1'b0;
    check("clr_vs_new_err", 32'(cfg_err), 32'b01);
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;

    // Write HIZ to pad 0 together with commit
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = 7'h03; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    check("wc_oe0_before", 32'(bidir_oe[0]), 32'd1);
    tick();
    check("wc_pad0_hiz", 32'({bidir_out[0], bidir_oe[0]}), 32'b00);
    wait_ready("wc_commit_end");
    tick();

    // Reset during commit cycle 5 aborts and restores defaults
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("ra_in_commit", 32'(cfg_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("ra_ready", 32'(cfg_ready), 32'd1);
    check("ra_pad0", 32'({bidir_out[0], bidir_oe[0]}), 32'b11);
    check("ra_pad3", 32'({bidir_out[3], bidir_oe[3]}), 32'b00);
    check("ra_inpd", 32'(input_pd), 32'd0);
    check("ra_flags", 32'({cfg_done, cfg_rvalid, cfg_err}), 32'd0);
    check("ra_rdata", 32'(cfg_rdata), 32'd0);
    read(40);
    check("ra_shadow40", 32'(cfg_rdata), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
